// File: rtl/sum_frame_accumulator_pkg.sv
// Shared definitions for the sum-stage consumer blocks: default widths and
// the frame accumulator state encoding.
package sum_pkg;

    localparam int SUM_DATA_W = 8;
    localparam int SUM_ACC_W  = 16;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

endpackage : sum_pkg

// File: rtl/sum_frame_accumulator_if.sv
// Stream bundle between the adder stage, the frame accumulator and the
// consumer of frame totals.
interface sum_frame_accumulator_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_total;
    logic              out_ovf;
    logic [CNT_W-1:0]  out_count;

    // Accumulator side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_total, out_ovf, out_count
    );

    // Environment side: upstream producer plus downstream consumer.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_total, out_ovf, out_count
    );
endinterface : sum_frame_accumulator_if

// File: rtl/sum_frame_accumulator.sv
// Reduces FRAME_LEN consecutive upstream sums to one ACC_W-bit total with a
// sticky wrap flag, held on the output until the consumer takes it.
module sum_frame_accumulator
    import sum_pkg::*;
#(
    parameter int DATA_W    = SUM_DATA_W,
    parameter int ACC_W     = SUM_ACC_W,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    sum_frame_accumulator_if.slave bus
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [ACC_W-1:0]   total_q, total_d;
    logic               ovf_q, ovf_d;

    logic               out_valid;
    logic               in_ready;
    logic               accept;
    logic               closing;
    logic [ACC_W:0]     sum_ext;

    assign out_valid = (state_q == HOLD);
    assign in_ready  = !clr && (!out_valid || bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign closing   = accept && (cnt_q == CNT_W'(FRAME_LEN - 1));

    // Extra top bit captures the carry out of the ACC_W-bit add.
    assign sum_ext = {1'b0, acc_q} + {{(ACC_W - DATA_W + 1){1'b0}}, bus.in_data};

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        total_d   = total_q;
        ovf_d     = ovf_q;

        if (state_q == HOLD && bus.out_ready) begin
            state_d = ACCUM;
        end

        if (clr) begin
            acc_d     = '0;
            cnt_d     = '0;
            ovf_acc_d = 1'b0;
        end else if (closing) begin
            // A closing accept wins over the release above: stay in HOLD.
            total_d   = sum_ext[ACC_W-1:0];
            ovf_d     = ovf_acc_q | sum_ext[ACC_W];
            state_d   = HOLD;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_acc_d = 1'b0;
        end else if (accept) begin
            acc_d     = sum_ext[ACC_W-1:0];
            cnt_d     = cnt_q + CNT_W'(1);
            ovf_acc_d = ovf_acc_q | sum_ext[ACC_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            total_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            total_q   <= total_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_total = total_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_count = cnt_q;

endmodule : sum_frame_accumulator

// File: tb/tb_sum_frame_accumulator.sv
// Directed bench: two accumulators (16-bit and 9-bit totals) share one stimulus
// stream and are compared every cycle against a frame-level sum model.
module tb_sum_frame_accumulator;
    localparam int FL    = 4;
    localparam int CNT_W = $clog2(FL + 1);

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    int n_checks = 0;
    int n_errors = 0;

    sum_frame_accumulator_if #(.DATA_W(8), .ACC_W(16), .CNT_W(CNT_W)) ifa ();
    sum_frame_accumulator_if #(.DATA_W(8), .ACC_W(9),  .CNT_W(CNT_W)) ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.in_data   = in_data;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_data   = in_data;
    assign ifb.out_ready = out_ready;

    sum_frame_accumulator #(.DATA_W(8), .ACC_W(16), .FRAME_LEN(FL), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifa)
    );
    sum_frame_accumulator #(.DATA_W(8), .ACC_W(9), .FRAME_LEN(FL), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: true integer sums, wrapped only when presented.
    bit m_valid;
    int m_sum, m_cnt, m_tot;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_sum = 0; m_cnt = 0; m_tot = 0;
        end else begin
            bit acc_ok;
            acc_ok = in_valid && !clr && (!m_valid || out_ready);
            if (m_valid && out_ready) m_valid = 0;
            if (clr) begin
                m_sum = 0; m_cnt = 0;
            end else if (acc_ok) begin
                m_sum += int'(in_data);
                m_cnt++;
                if (m_cnt == FL) begin
                    m_tot = m_sum; m_valid = 1; m_sum = 0; m_cnt = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        int exp_rdy;
        exp_rdy = (!clr && (!m_valid || out_ready)) ? 1 : 0;
        chk("a.in_ready",  ifa.in_ready,  exp_rdy);
        chk("a.out_valid", ifa.out_valid, m_valid);
        chk("a.out_total", ifa.out_total, m_tot % 65536);
        chk("a.out_ovf",   ifa.out_ovf,   (m_tot >= 65536) ? 1 : 0);
        chk("a.out_count", ifa.out_count, m_cnt);
        chk("b.in_ready",  ifb.in_ready,  exp_rdy);
        chk("b.out_valid", ifb.out_valid, m_valid);
        chk("b.out_total", ifb.out_total, m_tot % 512);
        chk("b.out_ovf",   ifb.out_ovf,   (m_tot >= 512) ? 1 : 0);
        chk("b.out_count", ifb.out_count, m_cnt);
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic c);
        in_valid = v; in_data = d; out_ready = r; clr = c;
    endtask

    task automatic send(input int d, input logic r);
        drive(1'b1, 8'(d), r, 1'b0);
        $display("send data=%0d out_ready=%0d", d, r);
        cyc();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 8'd0, 1'b1, 1'b0);
        cyc();
        chk("rst.out_valid", ifa.out_valid, 0);
        chk("rst.out_total", ifa.out_total, 0);
        chk("rst.out_count", ifa.out_count, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("rst.in_ready", ifa.in_ready, 1);

        // Basic frame.
        send(14, 1'b1); send(12, 1'b1); send(255, 1'b1); send(1, 1'b1);
        chk("basic.valid", ifa.out_valid, 1);
        chk("basic.total", ifa.out_total, 282);
        chk("basic.ovf",   ifa.out_ovf,   0);
        chk("basic.count", ifa.out_count, 0);
        drive(1'b0, 8'd0, 1'b1, 1'b0);
        cyc();
        chk("basic.taken", ifa.out_valid, 0);

        // Backpressure: held total, input stalled.
        send(14, 1'b0); send(12, 1'b0); send(255, 1'b0); send(1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'd10, 1'b0, 1'b0);
            cyc();
            chk("bp.total", ifa.out_total, 282);
            chk("bp.in_ready", ifa.in_ready, 0);
        end
        send(10, 1'b1); send(10, 1'b1); send(10, 1'b1); send(10, 1'b1);
        chk("bp.next_total", ifa.out_total, 40);
        drive(1'b0, 8'd0, 1'b1, 1'b0);
        cyc();

        // Overflow on the 9-bit instance, then a clean frame straight after.
        send(255, 1'b1); send(255, 1'b1); send(255, 1'b1); send(255, 1'b1);
        chk("ovf.b_total", ifb.out_total, 508);
        chk("ovf.b_ovf",   ifb.out_ovf,   1);
        chk("ovf.a_total", ifa.out_total, 1020);
        chk("ovf.a_ovf",   ifa.out_ovf,   0);
        send(1, 1'b1); send(1, 1'b1); send(1, 1'b1); send(1, 1'b1);
        chk("ovf.b_next_total", ifb.out_total, 4);
        chk("ovf.b_next_ovf",   ifb.out_ovf,   0);
        drive(1'b0, 8'd0, 1'b1, 1'b0);
        cyc();

        // Back-to-back frames with no stall.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 8'(i), 1'b1, 1'b0);
            #1;
            chk("b2b.in_ready", ifa.in_ready, 1);
            $display("send data=%0d out_ready=1", i);
            cyc();
            if (i == 4) chk("b2b.total1", ifa.out_total, 10);
        end
        chk("b2b.total2", ifa.out_total, 26);
        chk("b2b.valid2", ifa.out_valid, 1);
        drive(1'b0, 8'd0, 1'b1, 1'b0);
        cyc();

        // Synchronous clear of a partial frame.
        send(5, 1'b1); send(6, 1'b1);
        chk("clr.count_before", ifa.out_count, 2);
        drive(1'b1, 8'd7, 1'b1, 1'b1);
        #1;
        chk("clr.in_ready", ifa.in_ready, 0);
        cyc();
        chk("clr.count_after", ifa.out_count, 0);
        send(1, 1'b1); send(2, 1'b1); send(3, 1'b1); send(4, 1'b1);
        chk("clr.total", ifa.out_total, 10);
        drive(1'b0, 8'd0, 1'b1, 1'b0);
        cyc();

        // Asynchronous reset mid-frame.
        send(3, 1'b1); send(4, 1'b1);
        drive(1'b0, 8'd0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.count", ifa.out_count, 0);
        chk("arst.valid", ifa.out_valid, 0);
        cyc();
        rst_n = 1'b1;
        send(2, 1'b0); send(2, 1'b0); send(2, 1'b0); send(2, 1'b0);
        chk("arst.frame_total", ifa.out_total, 8);

        // Asynchronous reset while holding a total.
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_hold.valid", ifa.out_valid, 0);
        chk("arst_hold.total", ifa.out_total, 0);
        cyc();
        rst_n = 1'b1;
        send(9, 1'b1); send(9, 1'b1); send(9, 1'b1); send(9, 1'b1);
        chk("arst_hold.next_total", ifa.out_total, 36);
        drive(1'b0, 8'd0, 1'b1, 1'b0);
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule : tb_sum_frame_accumulator
